// File: rtl/muldiv_seq.sv
// Iterative radix-2 RV32M multiply/divide unit: one shift-add or restoring-subtract step per clock.
// Optional MULDIV_EARLY_OUT_EN: trivial ops (zero operand, div-by-zero, signed overflow) skip the iteration.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      aluSelect,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            ready,
  output logic            valid_out,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [5:0] OP_MUL    = 6'b101001;
  localparam logic [5:0] OP_MULH   = 6'b101010;
  localparam logic [5:0] OP_MULHSU = 6'b101011;
  localparam logic [5:0] OP_MULHU  = 6'b101100;
  localparam logic [5:0] OP_DIV    = 6'b101101;
  localparam logic [5:0] OP_DIVU   = 6'b101110;
  localparam logic [5:0] OP_REM    = 6'b101111;
  localparam logic [5:0] OP_REMU   = 6'b110000;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              is_div_q, is_div_d;
  logic              sel_hi_q, sel_hi_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q, valid_d;

  logic op_legal, op_div, op_hi, a_signed, b_signed;
  logic sa, sb, accept, early;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    op_legal = 1'b1;
    op_div   = 1'b0;
    op_hi    = 1'b0;
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (aluSelect)
      OP_MUL:    begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; op_hi = 1'b1; end
      OP_MULHSU: begin a_signed = 1'b1; op_hi = 1'b1; end
      OP_MULHU:  op_hi = 1'b1;
      OP_DIV:    begin op_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      OP_DIVU:   op_div = 1'b1;
      OP_REM:    begin op_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; op_hi = 1'b1; end
      OP_REMU:   begin op_div = 1'b1; op_hi = 1'b1; end
      default:   op_legal = 1'b0;
    endcase
  end

  assign sa     = a_signed & rs1[XLEN-1];
  assign sb     = b_signed & rs2[XLEN-1];
  assign a_mag  = sa ? -rs1 : rs1;
  assign b_mag  = sb ? -rs2 : rs2;
  assign accept = (state_q == S_IDLE) && start && op_legal;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = op_div ? ((rs2 == '0) ||
                           (a_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2)))
                        : ((rs1 == '0) || (rs2 == '0));
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = early ? S_FIN : S_CALC;
      S_CALC:  if (cnt_q == CW'(XLEN-1)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // p_q holds {accumulator, multiplier} for MUL* and {remainder, dividend/quotient} for DIV*.
  logic [XLEN:0]     mul_sum, div_r;
  logic [2*XLEN-1:0] mul_next, div_next, mul_full;
  logic [XLEN-1:0]   div_sub, div_sel, div_res, mul_res, fin_res;
  logic              div_ge;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, p_q[XLEN-1:1]};
    div_r    = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_ge   = div_r >= {1'b0, opnd_q};
    div_sub  = div_r[XLEN-1:0] - opnd_q;
    div_next = {div_ge ? div_sub : div_r[XLEN-1:0], p_q[XLEN-2:0], div_ge};
    mul_full = neg_q ? -p_q : p_q;
    mul_res  = sel_hi_q ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
    div_sel  = sel_hi_q ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
    div_res  = neg_q ? -div_sel : div_sel;
    fin_res  = is_div_q ? div_res : mul_res;
  end

  always_comb begin
    cnt_d    = cnt_q;
    p_d      = p_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    if (accept) begin
      cnt_d    = '0;
      is_div_d = op_div;
      sel_hi_d = op_hi;
      opnd_d   = op_div ? b_mag : a_mag;
      p_d      = {{XLEN{1'b0}}, op_div ? a_mag : b_mag};
      // Quotient of a divide by zero stays all ones; remainder follows the dividend.
      neg_d    = op_div ? (op_hi ? sa : ((sa ^ sb) && (rs2 != '0))) : (sa ^ sb);
      if (early) begin
        if (!op_div)          p_d = '0;
        else if (rs2 == '0)   p_d = {a_mag, {XLEN{1'b1}}};
      end
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q + 1'b1;
      p_d   = is_div_q ? div_next : mul_next;
    end
  end

  always_comb begin
    ready    = (state_q == S_IDLE);
    valid_d  = (state_q == S_FIN);
    result_d = (state_q == S_FIN) ? fin_res : result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      p_q      <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign valid_out = valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: arithmetic, boundary cases, latency, busy/back-to-back, reset abort.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  aluSelect;
  logic [31:0] rs1, rs2;
  logic        ready, valid_out;
  logic [31:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_EDGE = 2;
`else
  localparam int LAT_EDGE = 34;
`endif

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluSelect(aluSelect),
    .rs1(rs1), .rs2(rs2), .ready(ready), .valid_out(valid_out), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse; returns #1 after the accepting edge.
  task automatic issue(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; aluSelect = sel; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Latency counts the accepting edge as clock 1; bounded at 100.
  task automatic wait_valid(output int n, output logic [31:0] res);
    n = 1;
    while (!valid_out && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; aluSelect = '0; rs1 = '0; rs2 = '0;
    #12;
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else pass_cnt++;
    total_cnt++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_out); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 0", result); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [5:0]  sels [4] = '{6'b101001, 6'b101010, 6'b101011, 6'b101100};
    logic [31:0] as   [4] = '{32'd6, 32'hFFFFFFF6, 32'hFFFFFFF6, 32'd50000};
    logic [31:0] bs   [4] = '{32'd7, 32'd100000, 32'd100000, 32'd100000};
    logic [31:0] exps [4] = '{32'd42, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    int n; logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      issue(sels[i], as[i], bs[i]);
      total_cnt++; if (ready !== 1'b0) $display("FAIL mul%0d_busy: ready got %b expected 0", i, ready); else pass_cnt++;
      wait_valid(n, res);
      total_cnt++; if (res !== exps[i]) $display("FAIL mul%0d_result: got %h expected %h", i, res, exps[i]); else pass_cnt++;
      total_cnt++; if (n !== 34) $display("FAIL mul%0d_latency: got %0d expected 34", i, n); else pass_cnt++;
      total_cnt++; if (ready !== 1'b1) $display("FAIL mul%0d_ready_at_valid: got %b expected 1", i, ready); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (valid_out !== 1'b0) $display("FAIL mul%0d_pulse_width: got %b expected 0", i, valid_out); else pass_cnt++;
      total_cnt++; if (result !== exps[i]) $display("FAIL mul%0d_hold: got %h expected %h", i, result, exps[i]); else pass_cnt++;
    end
  endtask

  task automatic test_div();
    logic [5:0]  sels [4] = '{6'b101101, 6'b101110, 6'b101111, 6'b110000};
    logic [31:0] as   [4] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9B, 32'd101};
    logic [31:0] bs   [4] = '{32'd25, 32'd25, 32'd20, 32'd20};
    logic [31:0] exps [4] = '{32'hFFFFFFFC, 32'd4, 32'hFFFFFFFF, 32'd1};
    int n; logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      issue(sels[i], as[i], bs[i]);
      wait_valid(n, res);
      total_cnt++; if (res !== exps[i]) $display("FAIL div%0d_result: got %h expected %h", i, res, exps[i]); else pass_cnt++;
      total_cnt++; if (n !== 34) $display("FAIL div%0d_latency: got %0d expected 34", i, n); else pass_cnt++;
    end
  endtask

  task automatic test_boundary();
    logic [5:0]  sels [5] = '{6'b101101, 6'b101111, 6'b101101, 6'b101111, 6'b101110};
    logic [31:0] as   [5] = '{32'd123, 32'd123, 32'h80000000, 32'h80000000, 32'hFFFFFF9C};
    logic [31:0] bs   [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] exps [5] = '{32'hFFFFFFFF, 32'd123, 32'h80000000, 32'd0, 32'hFFFFFFFF};
    int n; logic [31:0] res;
    for (int i = 0; i < 5; i++) begin
      issue(sels[i], as[i], bs[i]);
      wait_valid(n, res);
      total_cnt++; if (res !== exps[i]) $display("FAIL bnd%0d_result: got %h expected %h", i, res, exps[i]); else pass_cnt++;
      total_cnt++; if (n !== LAT_EDGE) $display("FAIL bnd%0d_latency: got %0d expected %0d", i, n, LAT_EDGE); else pass_cnt++;
    end
    // Negative dividend by zero: remainder keeps the dividend's sign
    issue(6'b101111, 32'hFFFFFF9B, 32'd0);
    wait_valid(n, res);
    total_cnt++; if (res !== 32'hFFFFFF9B) $display("FAIL rem_neg_div0: got %h expected ffffff9b", res); else pass_cnt++;
  endtask

  task automatic test_illegal();
    issue(6'b000000, 32'd5, 32'd5);
    total_cnt++; if (ready !== 1'b1) $display("FAIL illegal_ready: got %b expected 1", ready); else pass_cnt++;
    repeat (3) @(posedge clk); #1;
    total_cnt++; if (valid_out !== 1'b0) $display("FAIL illegal_valid: got %b expected 0", valid_out); else pass_cnt++;
  endtask

  task automatic test_busy_start();
    int n; logic [31:0] res;
    issue(6'b101001, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; aluSelect = 6'b101110; rs1 = 32'd100; rs2 = 32'd25;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++; if (ready !== 1'b0) $display("FAIL busy_ready: got %b expected 0", ready); else pass_cnt++;
    n = 11;
    while (!valid_out && n < 100) begin @(posedge clk); #1; n++; end
    total_cnt++; if (result !== 32'd42) $display("FAIL busy_result: got %h expected 0000002a", result); else pass_cnt++;
    total_cnt++; if (n !== 34) $display("FAIL busy_latency: got %0d expected 34", n); else pass_cnt++;
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (valid_out) n++; end
    total_cnt++; if (n !== 0) $display("FAIL busy_no_queue: got %0d pulses expected 0", n); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] res;
    issue(6'b101100, 32'd50000, 32'd100000);
    wait_valid(n, res);
    total_cnt++; if (res !== 32'h1) $display("FAIL b2b_first: got %h expected 00000001", res); else pass_cnt++;
    start = 1'b1; aluSelect = 6'b101110; rs1 = 32'd100; rs2 = 32'd25;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++; if (ready !== 1'b0) $display("FAIL b2b_accept: ready got %b expected 0", ready); else pass_cnt++;
    repeat (5) @(posedge clk); #1;
    total_cnt++; if (result !== 32'h1) $display("FAIL b2b_hold: got %h expected 00000001", result); else pass_cnt++;
    n = 6;
    while (!valid_out && n < 100) begin @(posedge clk); #1; n++; end
    total_cnt++; if (result !== 32'd4) $display("FAIL b2b_second: got %h expected 00000004", result); else pass_cnt++;
    total_cnt++; if (n !== 34) $display("FAIL b2b_latency: got %0d expected 34", n); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    int n;
    issue(6'b101101, 32'hFFFFFF9C, 32'd25);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", ready); else pass_cnt++;
    total_cnt++; if (valid_out !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", valid_out); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL rstmid_result: got %h expected 0", result); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (valid_out) n++; end
    total_cnt++; if (n !== 0) $display("FAIL rstmid_no_pulse: got %0d pulses expected 0", n); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_boundary();
    test_illegal();
    test_busy_start();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
